spi_reg_master: RTL and testbench

- Initiator end of the two-byte register-access SPI protocol: turns a parallel register request into an SPI mode-0 transaction.
- Drives cs_n/sclk/mosi toward the peripheral's SPI slave and instruction decoder, samples miso, and returns read data.
- Used by the top-level test harness and by a future on-chip controller to program the PWM peripheral registers.

---
 rtl/spi_reg_pkg.sv | 20 ++
 rtl/spi_reg_master_if.sv | 16 +
 rtl/spi_clk_gen.sv | 42 ++++
 rtl/spi_reg_master.sv | 104 ++++++++++
 tb/tb_spi_reg_master.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared types, widths and frame builder for the SPI register master
package spi_reg_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT0, GAP, SHIFT1, HOLD, DONE} state_t;

    localparam int CMD_WRITE_BIT = 7;
    localparam int ADDR_W        = 6;
    localparam int DATA_W        = 8;
    localparam int FRAME_BITS    = 16;

    // byte0 = {write, 0, addr}; byte1 carries data only for writes
    function automatic logic [FRAME_BITS-1:0] frame(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] b0;
        b0 = '0;
        b0[CMD_WRITE_BIT] = w;
        b0[ADDR_W-1:0] = a;
        return {b0, w ? d : {DATA_W{1'b0}}};
    endfunction

endpackage

// File: rtl/spi_reg_master_if.sv
// spi_reg_master_if: request/response handshake between a requester and spi_reg_master
//   req_valid/req_ready/req_write/req_addr/req_wdata : request channel
//   resp_valid/resp_rdata                            : one-cycle response
//   modport master = requester side, modport slave = spi_reg_master side
interface spi_reg_master_if;
    import spi_reg_pkg::*;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    modport master(output req_valid, req_write, req_addr, req_wdata, input req_ready, resp_valid, resp_rdata);
    modport slave(input req_valid, req_write, req_addr, req_wdata, output req_ready, resp_valid, resp_rdata);
endinterface

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: phase divider producing sclk plus rise/fall strobes and phase-done
//   load/load_val : start a phase lasting load_val clk cycles (takes priority)
//   toggle_en     : when the running phase ends, flip sclk and start a CLK_DIV half-period
//   sclk          : registered SPI clock, idle low
//   rise/fall     : high in the clk cycle whose closing edge flips sclk up/down
//   phase_done    : current phase is in its last cycle
module spi_clk_gen #(
    parameter int CLK_DIV = 4,
    parameter int CW      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          toggle_en,
    output logic          sclk,
    output logic          rise,
    output logic          fall,
    output logic          phase_done
);
    logic [CW-1:0] cnt;
    logic          tick;

    assign phase_done = cnt == '0;
    assign tick       = toggle_en && !load && phase_done;
    assign rise       = tick && !sclk;
    assign fall       = tick && sclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (load) begin
            cnt <= load_val - 1'b1;
        end else if (tick) begin
            cnt  <= CW'(CLK_DIV - 1);
            sclk <= ~sclk;
        end else if (!phase_done) begin
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/spi_reg_master.sv
// spi_reg_master: turns a parallel register request into a two-byte SPI mode-0 transaction
//   clk, rst_n        : system clock, asynchronous active-low reset
//   req (slave)       : request in, one-cycle response out with read data
//   busy              : transaction in progress
//   cs_n/sclk/mosi    : SPI outputs, MSB first; miso : SPI input, synchronous to clk
module spi_reg_master
    import spi_reg_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int BYTE_GAP = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_reg_master_if.slave   req,
    output logic              busy,
    output logic              cs_n,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso
);
    localparam int CW = $clog2(CLK_DIV * BYTE_GAP + 1);

    state_t                  state;
    logic [FRAME_BITS-1:0]   sh;
    logic [DATA_W-1:0]       rx;
    logic                    wr;
    logic [2:0]              bit_cnt;
    logic                    accept, step, byte_end, load, toggle_en, rise, fall, phase_done;
    logic [CW-1:0]           load_val;

    // step marks the end of a bit's low half; the 8th one closes the byte
    assign accept    = req.req_valid && req.req_ready;
    assign step      = (state == SHIFT0 || state == SHIFT1) && phase_done && !sclk;
    assign byte_end  = step && bit_cnt == 3'd7;
    assign load      = accept || byte_end;
    assign load_val  = (state == SHIFT0) ? CW'(BYTE_GAP * CLK_DIV) : CW'(CLK_DIV);
    assign toggle_en = state == SETUP || state == SHIFT0 || state == GAP || state == SHIFT1;

    spi_clk_gen #(.CLK_DIV(CLK_DIV), .CW(CW)) u_clk_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_val   (load_val),
        .toggle_en  (toggle_en),
        .sclk       (sclk),
        .rise       (rise),
        .fall       (fall),
        .phase_done (phase_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            req.req_ready  <= 1'b1;
            req.resp_valid <= 1'b0;
            req.resp_rdata <= '0;
            busy           <= 1'b0;
            cs_n           <= 1'b1;
            mosi           <= 1'b0;
            sh             <= '0;
            rx             <= '0;
            wr             <= 1'b0;
            bit_cnt        <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state         <= SETUP;
                    req.req_ready <= 1'b0;
                    busy          <= 1'b1;
                    cs_n          <= 1'b0;
                    wr            <= req.req_write;
                    sh            <= frame(req.req_write, req.req_addr, req.req_wdata);
                    mosi          <= req.req_write;
                end
                SETUP: if (phase_done) state <= SHIFT0;
                SHIFT0, SHIFT1: begin
                    if (fall) begin
                        sh   <= sh << 1;
                        mosi <= sh[FRAME_BITS-2];
                    end
                    if (step) bit_cnt <= bit_cnt + 3'd1;
                    if (byte_end) state <= (state == SHIFT0) ? GAP : HOLD;
                end
                GAP: if (phase_done) state <= SHIFT1;
                HOLD: if (phase_done) begin
                    state          <= DONE;
                    cs_n           <= 1'b1;
                    busy           <= 1'b0;
                    mosi           <= 1'b0;
                    req.resp_valid <= 1'b1;
                    req.resp_rdata <= wr ? '0 : rx;
                end
                DONE: begin
                    state          <= IDLE;
                    req.resp_valid <= 1'b0;
                    req.req_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            // the first byte1 rise happens at the end of GAP
            if (rise && (state == GAP || state == SHIFT1)) rx <= {rx[DATA_W-2:0], miso};
        end
    end
endmodule

// File: tb/tb_spi_reg_master.sv
// tb_spi_reg_master: scoreboard bench for spi_reg_master with directed requests
module tb_spi_reg_master;
    logic clk, rst_n, busy, cs_n, sclk, mosi, miso;
    logic [7:0] miso_data;
    int total, bad, cyc, rc, last_rise, last_fall, resp_cnt;
    logic [15:0] word;

    typedef struct {
        logic [15:0] frame;
        logic [7:0]  rdata;
        int          t;
    } exp_t;
    exp_t sb[$];

    spi_reg_master_if bus();

    spi_reg_master #(.CLK_DIV(4), .BYTE_GAP(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (bus),
        .busy  (busy),
        .cs_n  (cs_n),
        .sclk  (sclk),
        .mosi  (mosi),
        .miso  (miso)
    );

    // slave model: byte1 bits presented MSB first, advancing after each observed rise
    assign miso = (rc >= 8 && rc < 16) ? miso_data[3'(15 - rc)] : 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string n, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", n, got, exp);
        end
    endtask

    // monitor: tracks the SPI frame and pops the scoreboard on every response
    initial begin
        logic prev_cs, prev_sclk;
        exp_t e;
        prev_cs = 1'b1; prev_sclk = 1'b0;
        rc = 0; word = '0; last_rise = 0; last_fall = 0; resp_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rc = 0;
                word = '0;
            end else begin
                if (!cs_n && prev_cs) begin
                    rc = 0;
                    last_fall = cyc;
                end
                if (cs_n && !prev_cs) last_rise = cyc;
                if (!cs_n && sclk && !prev_sclk) begin
                    word = {word[14:0], mosi};
                    rc++;
                end
                if (bus.resp_valid) begin
                    resp_cnt++;
                    if (sb.size() == 0) begin
                        chk("unexpected_resp", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("rdata", int'(bus.resp_rdata), int'(e.rdata));
                        chk("frame", int'(word), int'(e.frame));
                        chk("rises", rc, 16);
                        chk("latency", cyc - e.t, 145);
                        chk("resp_cs_n", int'(cs_n), 1);
                        chk("resp_busy", int'(busy), 0);
                    end
                end
            end
            prev_cs = cs_n;
            prev_sclk = sclk;
        end
    end

    task automatic issue(input logic w, input logic [5:0] a, input logic [7:0] d,
                         input logic [15:0] ef, input logic [7:0] er, input bit keep, output int t);
        int n;
        n = 0;
        t = -1;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        while (!bus.req_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            chk("accept_timeout", 0, 1);
        end else begin
            t = cyc;
            sb.push_back('{ef, er, cyc});
        end
        @(negedge clk);
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || !bus.req_ready) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        int t, t1, t2, n;
        total = 0; bad = 0;
        rst_n = 1'b0;
        miso_data = 8'h00;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", int'(cs_n), 1);
        chk("rst_sclk", int'(sclk), 0);
        chk("rst_mosi", int'(mosi), 0);
        chk("rst_ready", int'(bus.req_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_resp_valid", int'(bus.resp_valid), 0);
        chk("rst_rdata", int'(bus.resp_rdata), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_cs_n", int'(cs_n), 1);
        chk("idle_sclk", int'(sclk), 0);
        chk("idle_ready", int'(bus.req_ready), 1);
        chk("idle_no_resp", resp_cnt, 0);

        issue(1'b1, 6'h05, 8'hA5, 16'h85A5, 8'h00, 1'b0, t);
        wait_idle();

        miso_data = 8'h3C;
        issue(1'b0, 6'h12, 8'h00, 16'h1200, 8'h3C, 1'b0, t);
        wait_idle();

        miso_data = 8'hC3;
        issue(1'b1, 6'h2A, 8'h5A, 16'hAA5A, 8'h00, 1'b1, t1);
        issue(1'b0, 6'h33, 8'h77, 16'h3300, 8'hC3, 1'b0, t2);
        chk("b2b_accept", t2 - t1, 146);
        @(negedge clk);
        chk("cs_gap", last_fall - last_rise, 2);
        wait_idle();

        issue(1'b1, 6'h01, 8'h11, 16'h8111, 8'h00, 1'b0, t);
        repeat (10) @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 6'h3E;
        bus.req_wdata = 8'hEE;
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        chk("pulse_one_resp", resp_cnt, 5);

        miso_data = 8'h55;
        issue(1'b0, 6'h21, 8'h00, 16'h2100, 8'h55, 1'b0, t);
        n = 0;
        while (rc < 12 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_byte1", int'(rc >= 12), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_cs_n", int'(cs_n), 1);
        chk("abort_sclk", int'(sclk), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(bus.req_ready), 1);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_resp", resp_cnt, 5);

        issue(1'b1, 6'h3F, 8'hFF, 16'hBFFF, 8'h00, 1'b0, t);
        wait_idle();
        repeat (5) @(negedge clk);
        chk("resp_count", resp_cnt, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
